// File: rtl/alias_reduction_ctrl_pkg.sv
// Shared constants and FSM encoding for the MP3 alias-reduction sequencer.
package alias_reduction_ctrl_pkg;

  localparam int         SB_LEN          = 18;
  localparam int         NUM_BOUNDARIES  = 31;
  localparam int         NUM_BUTTERFLIES = 8;
  localparam int         COEF_W          = 18;
  localparam logic [1:0] BLOCK_SHORT     = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_CAP   = 3'd3,
    ST_MUL   = 3'd4,
    ST_WR_LO = 3'd5,
    ST_WR_HI = 3'd6,
    ST_FIN   = 3'd7
  } state_e;

endpackage

// File: rtl/alias_reduction_ctrl_butterfly.sv
// Registered alias-reduction butterfly: lo' = lo*cs - hi*ca, hi' = hi*cs + lo*ca,
// each floored by COEF_FRAC and clamped to the signed DATA_W range.
module alias_reduction_ctrl_butterfly
  import alias_reduction_ctrl_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int COEF_FRAC = 17
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] lo_i,
  input  logic signed [DATA_W-1:0] hi_i,
  input  logic signed [COEF_W-1:0] cs_i,
  input  logic signed [COEF_W-1:0] ca_i,
  output logic signed [DATA_W-1:0] lo_o,
  output logic signed [DATA_W-1:0] hi_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int HEAD_W = SUM_W - DATA_W + 1;

  logic        [PROD_W-1:0] p_lo_cs, p_hi_ca, p_hi_cs, p_lo_ca;
  logic signed [SUM_W-1:0]  sum_lo, sum_hi;
  logic signed [DATA_W-1:0] lo_d, lo_q, hi_d, hi_q;

  // Low PROD_W bits of a two's-complement product do not depend on operand signedness.
  function automatic logic [PROD_W-1:0] smul(input logic signed [DATA_W-1:0] a,
                                             input logic signed [COEF_W-1:0] b);
    smul = {{COEF_W{a[DATA_W-1]}}, a} * {{DATA_W{b[COEF_W-1]}}, b};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] s;
    s = x >>> COEF_FRAC;
    if (s[SUM_W-1:DATA_W-1] == {HEAD_W{s[SUM_W-1]}}) begin
      sat = s[DATA_W-1:0];
    end else if (s[SUM_W-1]) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  always_comb begin
    p_lo_cs = smul(lo_i, cs_i);
    p_hi_ca = smul(hi_i, ca_i);
    p_hi_cs = smul(hi_i, cs_i);
    p_lo_ca = smul(lo_i, ca_i);
    sum_lo  = {p_lo_cs[PROD_W-1], p_lo_cs} - {p_hi_ca[PROD_W-1], p_hi_ca};
    sum_hi  = {p_hi_cs[PROD_W-1], p_hi_cs} + {p_lo_ca[PROD_W-1], p_lo_ca};
    if (en_i) begin
      lo_d = sat(sum_lo);
      hi_d = sat(sum_hi);
    end else begin
      lo_d = lo_q;
      hi_d = hi_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lo_q <= {DATA_W{1'b0}};
      hi_q <= {DATA_W{1'b0}};
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/alias_reduction_ctrl.sv
// Alias-reduction sequencer: walks the subband-boundary butterflies of one granule,
// reads sample pairs and cs/ca coefficients, and writes the results back in place.
module alias_reduction_ctrl
  import alias_reduction_ctrl_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 10,
  parameter int COEF_FRAC = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [1:0]        block_type_i,
  input  logic              mixed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rd_en_o,
  output logic              ram_wr_en_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              rom_en_o,
  output logic [2:0]        rom_index_o,
  input  logic [COEF_W-1:0] cs_data_i,
  input  logic [COEF_W-1:0] ca_data_i
);

  localparam logic [4:0] SB_FIRST  = 5'd1;
  localparam logic [4:0] SB_LAST   = 5'(NUM_BOUNDARIES);
  localparam logic [2:0] I_LAST    = 3'(NUM_BUTTERFLIES - 1);

  state_e                   state_q, state_d;
  logic [4:0]               sb_q, sb_d, last_sb_q, last_sb_d;
  logic [2:0]               i_q, i_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic signed [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic signed [COEF_W-1:0] cs_q, cs_d, ca_q, ca_d;
  logic [ADDR_W-1:0]        seg_addr, lo_addr, hi_addr;
  logic signed [DATA_W-1:0] bf_lo, bf_hi;

  // Butterfly (sb,i) straddles the boundary at base + 18*sb; addresses wrap silently.
  always_comb begin
    seg_addr = base_q + ADDR_W'(sb_q) * ADDR_W'(SB_LEN);
    lo_addr  = seg_addr - ADDR_W'(1) - ADDR_W'(i_q);
    hi_addr  = seg_addr + ADDR_W'(i_q);
  end

  always_comb begin
    state_d   = state_q;
    sb_d      = sb_q;
    i_d       = i_q;
    base_d    = base_q;
    last_sb_d = last_sb_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          sb_d   = SB_FIRST;
          i_d    = 3'd0;
          if (block_type_i == BLOCK_SHORT && !mixed_i) begin
            state_d = ST_FIN;
          end else begin
            last_sb_d = (block_type_i == BLOCK_SHORT) ? SB_FIRST : SB_LAST;
            state_d   = ST_RD_LO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_LO: state_d = ST_RD_HI;
      ST_RD_HI: state_d = ST_CAP;
      ST_CAP:   state_d = ST_MUL;
      ST_MUL:   state_d = ST_WR_LO;
      ST_WR_LO: state_d = ST_WR_HI;
      ST_WR_HI: begin
        if (i_q == I_LAST) begin
          i_d = 3'd0;
          if (sb_q == last_sb_q) begin
            sb_d    = SB_FIRST;
            state_d = ST_FIN;
          end else begin
            sb_d    = sb_q + 5'd1;
            state_d = ST_RD_LO;
          end
        end else begin
          i_d     = i_q + 3'd1;
          state_d = ST_RD_LO;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read data for lo (and the coefficients) arrives in RD_HI, for hi in CAP.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    cs_d = cs_q;
    ca_d = ca_q;
    if (state_q == ST_RD_HI) begin
      lo_d = $signed(ram_rdata_i);
      cs_d = $signed(cs_data_i);
      ca_d = $signed(ca_data_i);
    end else if (state_q == ST_CAP) begin
      hi_d = $signed(ram_rdata_i);
    end else begin
      lo_d = lo_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      sb_q      <= SB_FIRST;
      i_q       <= 3'd0;
      last_sb_q <= SB_FIRST;
      base_q    <= {ADDR_W{1'b0}};
      lo_q      <= {DATA_W{1'b0}};
      hi_q      <= {DATA_W{1'b0}};
      cs_q      <= {COEF_W{1'b0}};
      ca_q      <= {COEF_W{1'b0}};
    end else begin
      state_q   <= state_d;
      sb_q      <= sb_d;
      i_q       <= i_d;
      last_sb_q <= last_sb_d;
      base_q    <= base_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cs_q      <= cs_d;
      ca_q      <= ca_d;
    end
  end

  alias_reduction_ctrl_butterfly #(
    .DATA_W    (DATA_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_butterfly (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (state_q == ST_MUL),
    .lo_i    (lo_q),
    .hi_i    (hi_q),
    .cs_i    (cs_q),
    .ca_i    (ca_q),
    .lo_o    (bf_lo),
    .hi_o    (bf_hi)
  );

  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    ram_addr_o  = {ADDR_W{1'b0}};
    ram_rd_en_o = 1'b0;
    ram_wr_en_o = 1'b0;
    ram_wdata_o = {DATA_W{1'b0}};
    rom_en_o    = 1'b0;
    rom_index_o = 3'd0;
    case (state_q)
      ST_RD_LO: begin
        busy_o      = 1'b1;
        ram_rd_en_o = 1'b1;
        ram_addr_o  = lo_addr;
        rom_en_o    = 1'b1;
        rom_index_o = i_q;
      end
      ST_RD_HI: begin
        busy_o      = 1'b1;
        ram_rd_en_o = 1'b1;
        ram_addr_o  = hi_addr;
      end
      ST_CAP:   busy_o = 1'b1;
      ST_MUL:   busy_o = 1'b1;
      ST_WR_LO: begin
        busy_o      = 1'b1;
        ram_wr_en_o = 1'b1;
        ram_addr_o  = lo_addr;
        ram_wdata_o = bf_lo;
      end
      ST_WR_HI: begin
        busy_o      = 1'b1;
        ram_wr_en_o = 1'b1;
        ram_addr_o  = hi_addr;
        ram_wdata_o = bf_hi;
      end
      ST_FIN:   done_o = 1'b1;
      default:  busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alias_reduction_ctrl.sv
// Self-checking bench for alias_reduction_ctrl: RAM/ROM models, vector table,
// corner-case sequences and randomized granules against a reference model.
module tb_alias_reduction_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset, start, mixed, load_req;
  logic [1:0]  block_type;
  logic [9:0]  base_addr;
  logic        busy, done, rd_en, wr_en, rom_en;
  logic [9:0]  ram_addr;
  logic [23:0] ram_wdata, ram_rdata;
  logic [2:0]  rom_index;
  logic [17:0] cs_data, ca_data;

  logic signed [23:0] mem [DEPTH];
  logic signed [23:0] img [DEPTH];
  logic signed [23:0] exp_mem [DEPTH];
  int cs_tab [8];
  int ca_tab [8];

  int checks = 0;
  int failures = 0;
  int r_cyc, r_done, r_wr, r_busy_bad, r_proto_bad, r_wmin, r_wmax;

  typedef struct {
    int lo; int hi; int cs; int ca; int exp_lo; int exp_hi;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  alias_reduction_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .block_type_i (block_type),
    .mixed_i      (mixed),
    .busy_o       (busy),
    .done_o       (done),
    .ram_addr_o   (ram_addr),
    .ram_rd_en_o  (rd_en),
    .ram_wr_en_o  (wr_en),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .rom_en_o     (rom_en),
    .rom_index_o  (rom_index),
    .cs_data_i    (cs_data),
    .ca_data_i    (ca_data)
  );

  // Granule RAM and coefficient ROMs, 1-cycle read latency
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= img[k];
    end else if (wr_en) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (rd_en) ram_rdata <= mem[ram_addr];
    if (rom_en) begin
      cs_data <= 18'(cs_tab[rom_index]);
      ca_data <= 18'(ca_tab[rom_index]);
    end
  end

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint floor_q17(input longint x);
    longint q;
    q = x / 131072;
    if (x < 0 && (x % 131072) != 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp24(input longint x);
    if (x > 8388607) return 8388607;
    if (x < -8388608) return -8388608;
    return x;
  endfunction

  // Reference: apply the first 'limit' butterflies of the scope to img, result in exp_mem
  task automatic build_expected(input logic [1:0] bt, input logic mx, input int base, input int limit);
    int last, n, la, ha;
    longint lo, hi, cs, ca;
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = img[k];
    if (bt == 2'd2 && !mx) return;
    last = (bt == 2'd2) ? 1 : 31;
    n = 0;
    for (int sb = 1; sb <= last; sb++) begin
      for (int i = 0; i < 8; i++) begin
        if (n < limit) begin
          la = (base + 18 * sb - 1 - i) % DEPTH;
          ha = (base + 18 * sb + i) % DEPTH;
          lo = img[la]; hi = img[ha]; cs = cs_tab[i]; ca = ca_tab[i];
          exp_mem[la] = 24'(clamp24(floor_q17(lo * cs - hi * ca)));
          exp_mem[ha] = 24'(clamp24(floor_q17(hi * cs + lo * ca)));
        end
        n++;
      end
    end
  endtask

  task automatic compare_mem(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== exp_mem[k]) bad++;
    check(name, bad, 0);
  endtask

  task automatic load_img();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic random_img();
    for (int k = 0; k < DEPTH; k++) img[k] = 24'($urandom);
  endtask

  // Start one granule and observe until done plus a short tail; other inputs toggle freely
  task automatic run_granule(input logic [1:0] bt, input logic mx, input logic [9:0] base,
                             input int restart_at);
    r_cyc = -1; r_done = 0; r_wr = 0; r_busy_bad = 0; r_proto_bad = 0;
    r_wmin = DEPTH; r_wmax = -1;
    @(negedge clk);
    start = 1'b1; block_type = bt; mixed = mx; base_addr = base;
    for (int c = 1; c <= 2000 && !(r_cyc >= 0 && c > r_cyc + 8); c++) begin
      @(negedge clk);
      start = (c == restart_at);
      base_addr = 10'($urandom); block_type = 2'($urandom); mixed = 1'($urandom);
      if (done) begin
        r_done++;
        if (r_cyc < 0) r_cyc = c;
      end else if (r_cyc < 0 && !busy) begin
        r_busy_bad++;
      end
      if (rd_en && wr_en) r_proto_bad++;
      if (rom_en && !rd_en) r_proto_bad++;
      if (wr_en) begin
        r_wr++;
        if (int'(ram_addr) < r_wmin) r_wmin = int'(ram_addr);
        if (int'(ram_addr) > r_wmax) r_wmax = int'(ram_addr);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_cyc, input int exp_wr);
    check({tag, "_done_cycle"}, r_cyc, exp_cyc);
    check({tag, "_done_count"}, r_done, 1);
    check({tag, "_writes"}, r_wr, exp_wr);
    check({tag, "_busy_gap"}, r_busy_bad, 0);
    check({tag, "_strobe_rules"}, r_proto_bad, 0);
  endtask

  initial begin
    int b, nz, cyc_e, wr_e;
    logic [1:0] bt;
    logic mx;
    reset = 1'b1; start = 1'b0; load_req = 1'b0; block_type = 2'd0; mixed = 1'b0;
    base_addr = 10'd0;
    cs_tab = '{112393, 115571, 124469, 128884, 130484, 130962, 131059, 131071};
    ca_tab = '{-67436, -61830, -41075, -23844, -12396, -5369, -1861, -485};
    for (int k = 0; k < DEPTH; k++) img[k] = 24'sd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, rd_en, wr_en, rom_en, ram_addr, ram_wdata, rom_index}, 0);
    reset = 1'b0;

    // Single-butterfly arithmetic vectors run through a mixed (sb=1) granule at base 100
    vt[0] = '{1000, 0, 112393, -67436, 857, -515};
    vt[1] = '{8388607, 8388607, 92682, 92682, 0, 8388607};
    vt[2] = '{-8388608, -8388608, 92682, 92682, 0, -8388608};
    vt[3] = '{-1, 0, 1, 0, -1, 0};
    vt[4] = '{131072, -131072, 131071, -131072, -1, -262143};
    vt[5] = '{8388607, 0, -131072, 0, -8388607, 0};
    vt[6] = '{0, 8388607, 0, -131072, 8388607, 0};
    for (int v = 0; v < 7; v++) begin
      random_img();
      img[117] = 24'(vt[v].lo); img[118] = 24'(vt[v].hi);
      cs_tab[0] = vt[v].cs; ca_tab[0] = vt[v].ca;
      load_img();
      run_granule(2'd2, 1'b1, 10'd100, -1);
      check($sformatf("vec%0d_lo", v), mem[117], vt[v].exp_lo);
      check($sformatf("vec%0d_hi", v), mem[118], vt[v].exp_hi);
    end

    // Full long-block granule at base 0
    cs_tab[0] = 112393; ca_tab[0] = -67436;
    random_img(); img[17] = 24'sd1000; img[18] = 24'sd0;
    load_img();
    run_granule(2'd0, 1'b0, 10'd0, -1);
    check("full_ram17", mem[17], 857);
    check("full_ram18", mem[18], -515);
    check_run("full", 1489, 496);
    build_expected(2'd0, 1'b0, 0, 248);
    compare_mem("full_mem");

    // Mixed block at base 576: writes confined to 586..601
    random_img(); load_img();
    run_granule(2'd2, 1'b1, 10'd576, -1);
    check_run("mixed", 49, 16);
    check("mixed_wmin", r_wmin, 586);
    check("mixed_wmax", r_wmax, 601);
    build_expected(2'd2, 1'b1, 576, 8);
    compare_mem("mixed_mem");

    // Pure short block: nothing to do
    random_img(); load_img();
    run_granule(2'd2, 1'b0, 10'd300, -1);
    check("short_done_cycle", r_cyc, 1);
    check("short_done_count", r_done, 1);
    check("short_writes", r_wr, 0);
    build_expected(2'd2, 1'b0, 300, 0);
    compare_mem("short_mem");

    // Reset during MUL of butterfly 10 (state after the 64th edge), then a fresh granule
    random_img(); load_img();
    b = 1000;
    @(negedge clk); start = 1'b1; block_type = 2'd0; mixed = 1'b0; base_addr = 10'(b);
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk); start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {busy, done, rd_en, wr_en, rom_en, ram_addr, ram_wdata, rom_index}, 0);
    reset = 1'b0;
    nz = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || wr_en || busy) nz++;
    end
    check("abort_quiet", nz, 0);
    build_expected(2'd0, 1'b0, b, 10);
    compare_mem("abort_partial_mem");
    random_img(); load_img();
    run_granule(2'd0, 1'b0, 10'd40, -1);
    check_run("after_abort", 1489, 496);
    build_expected(2'd0, 1'b0, 40, 248);
    compare_mem("after_abort_mem");

    // Second start while busy must be ignored
    random_img(); load_img();
    run_granule(2'd1, 1'b0, 10'd900, 100);
    check_run("restart", 1489, 496);
    build_expected(2'd1, 1'b0, 900, 248);
    compare_mem("restart_mem");

    // Randomized granules, coefficients and data
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) begin
        cs_tab[k] = int'($urandom_range(0, 262143)) - 131072;
        ca_tab[k] = int'($urandom_range(0, 262143)) - 131072;
      end
      random_img(); load_img();
      bt = 2'($urandom_range(0, 3)); mx = 1'($urandom);
      b  = int'($urandom_range(0, DEPTH - 1));
      cyc_e = (bt == 2'd2 && !mx) ? 1 : ((bt == 2'd2) ? 49 : 1489);
      wr_e  = (bt == 2'd2 && !mx) ? 0 : ((bt == 2'd2) ? 16 : 496);
      run_granule(bt, mx, 10'(b), -1);
      check_run($sformatf("rand%0d", t), cyc_e, wr_e);
      build_expected(bt, mx, b, 248);
      compare_mem($sformatf("rand%0d_mem", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
